// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter that lets several instruction-cache miss ports share one
// program memory read port, with a single outstanding request at a time.
module program_mem_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16,
  localparam int GRANT_BITS = $clog2(NUM_CLIENTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           client_read_valid,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] client_read_address,
  output logic [NUM_CLIENTS-1:0]           client_read_ready,
  output logic [NUM_CLIENTS*DATA_BITS-1:0] client_read_data,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             busy,
  output logic [GRANT_BITS-1:0]            grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [GRANT_BITS-1:0]            ptr_q, ptr_d;
  logic [GRANT_BITS-1:0]            grant_q, grant_d;
  logic                             mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]             mem_addr_q, mem_addr_d;
  logic [NUM_CLIENTS-1:0]           ready_q, ready_d;
  logic [NUM_CLIENTS*DATA_BITS-1:0] data_q, data_d;

  logic                  pick_found;
  logic [GRANT_BITS-1:0] pick_idx;
  logic [ADDR_BITS-1:0]  pick_addr;

  // Search starts at the priority pointer and wraps, so the first hit is the winner.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = 0; off < NUM_CLIENTS; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (!pick_found && (cand == i) && client_read_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = GRANT_BITS'(i);
        end
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_idx == GRANT_BITS'(i)) pick_addr = client_read_address[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    ready_d     = '0;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          mem_valid_d = 1'b1;
          mem_addr_d  = pick_addr;
          ptr_d       = (pick_idx == GRANT_BITS'(NUM_CLIENTS - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = REQUEST;
        end
      end
      REQUEST: begin
        // Completion data lands in the granted slice and stays until that client's next completion.
        if (mem_read_ready) begin
          mem_valid_d = 1'b0;
          state_d     = RESPOND;
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q == GRANT_BITS'(i)) begin
              data_d[i*DATA_BITS +: DATA_BITS] = mem_read_data;
              ready_d[i] = 1'b1;
            end
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
    end
  end

  assign client_read_ready = ready_q;
  assign client_read_data  = data_q;
  assign mem_read_valid    = mem_valid_q;
  assign mem_read_address  = mem_addr_q;
  assign busy              = (state_q != IDLE);
  assign grant_id          = grant_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Directed bench for program_mem_arbiter: hand-computed grants, latencies and
// returned data for four clients, including reset abort and spurious memory completions.
module tb_program_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  client_read_valid;
  logic [31:0] client_read_address;
  logic [3:0]  client_read_ready;
  logic [63:0] client_read_data;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic        busy;
  logic [1:0]  grant_id;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_data [4];

  program_mem_arbiter #(
    .NUM_CLIENTS(4),
    .ADDR_BITS(8),
    .DATA_BITS(16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .client_read_valid   (client_read_valid),
    .client_read_address (client_read_address),
    .client_read_ready   (client_read_ready),
    .client_read_data    (client_read_data),
    .mem_read_valid      (mem_read_valid),
    .mem_read_address    (mem_read_address),
    .mem_read_ready      (mem_read_ready),
    .mem_read_data       (mem_read_data),
    .busy                (busy),
    .grant_id            (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] addrs);
    client_read_valid   = valid;
    client_read_address = addrs;
  endtask

  function automatic logic [63:0] expected_bus();
    return {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
  endfunction

  // Called during an IDLE cycle with the requests already applied; k is memory latency.
  task automatic serve(input int c, input logic [7:0] addr, input logic [15:0] data, input int k,
                       input logic [3:0] drop_at_grant, input logic [3:0] drop_at_respond);
    logic [3:0] exp_rdy;
    exp_rdy = 4'(1 << c);
    step();
    checkOutput("grant_id", 64'(grant_id), 64'(c));
    checkOutput("mem_valid_grant", 64'(mem_read_valid), 64'd1);
    checkOutput("mem_addr_grant", 64'(mem_read_address), 64'(addr));
    checkOutput("busy_request", 64'(busy), 64'd1);
    checkOutput("ready_request", 64'(client_read_ready), 64'd0);
    client_read_valid = client_read_valid & ~drop_at_grant;
    for (int i = 1; i < k; i++) begin
      step();
      checkOutput("mem_valid_hold", 64'(mem_read_valid), 64'd1);
      checkOutput("mem_addr_hold", 64'(mem_read_address), 64'(addr));
    end
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    step();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    exp_data[c]    = data;
    checkOutput("ready_pulse", 64'(client_read_ready), 64'(exp_rdy));
    checkOutput("data_respond", client_read_data, expected_bus());
    checkOutput("mem_valid_drop", 64'(mem_read_valid), 64'd0);
    checkOutput("busy_respond", 64'(busy), 64'd1);
    client_read_valid = client_read_valid & ~drop_at_respond;
    step();
    checkOutput("ready_clear", 64'(client_read_ready), 64'd0);
    checkOutput("busy_gap", 64'(busy), 64'd0);
    checkOutput("data_held", client_read_data, expected_bus());
  endtask

  initial begin
    reset          = 1'b1;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    applyStimulus(4'b0000, 32'h0);
    for (int i = 0; i < 4; i++) exp_data[i] = 16'h0000;

    step();
    step();
    checkOutput("rst_mem_valid", 64'(mem_read_valid), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_read_address), 64'd0);
    checkOutput("rst_ready", 64'(client_read_ready), 64'd0);
    checkOutput("rst_data", client_read_data, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_grant", 64'(grant_id), 64'd0);
    reset = 1'b0;
    step();

    $display("[TB] single request from client 2");
    applyStimulus(4'b0100, 32'h003C_0000);
    serve(2, 8'h3C, 16'hBEEF, 3, 4'b0100, 4'b0000);
    step();
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("beef_held", client_read_data, 64'h0000_BEEF_0000_0000);

    $display("[TB] spurious memory completion in IDLE");
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1234;
    step();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    checkOutput("spur_ready", 64'(client_read_ready), 64'd0);
    checkOutput("spur_data", client_read_data, expected_bus());
    checkOutput("spur_busy", 64'(busy), 64'd0);
    step();
    checkOutput("spur_ready_late", 64'(client_read_ready), 64'd0);

    $display("[TB] four simultaneous requests from reset");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_data[i] = 16'h0000;
    checkOutput("rst2_data", client_read_data, 64'd0);
    step();
    reset = 1'b0;
    applyStimulus(4'b1111, 32'h4030_2010);
    serve(0, 8'h10, 16'hA000, 1, 4'b0000, 4'b0001);
    serve(1, 8'h20, 16'hA001, 1, 4'b0000, 4'b0010);
    serve(2, 8'h30, 16'hA002, 1, 4'b0000, 4'b0100);
    serve(3, 8'h40, 16'hA003, 1, 4'b0000, 4'b1000);
    checkOutput("all_data", client_read_data, 64'hA003_A002_A001_A000);

    $display("[TB] fairness between client 0 and client 3");
    applyStimulus(4'b1001, 32'h7700_0011);
    serve(0, 8'h11, 16'hC000, 2, 4'b0000, 4'b0000);
    serve(3, 8'h77, 16'hC003, 1, 4'b0000, 4'b1000);
    serve(0, 8'h11, 16'hC100, 1, 4'b0000, 4'b0001);

    $display("[TB] client 1 drops valid during REQUEST");
    applyStimulus(4'b0010, 32'h0000_5500);
    serve(1, 8'h55, 16'hD001, 3, 4'b0010, 4'b0000);
    step();
    checkOutput("no_extra_grant_busy", 64'(busy), 64'd0);
    checkOutput("no_extra_grant_mem", 64'(mem_read_valid), 64'd0);

    $display("[TB] reset during REQUEST, then late memory completion");
    applyStimulus(4'b0010, 32'h0000_1000);
    step();
    checkOutput("abort_grant", 64'(grant_id), 64'd1);
    checkOutput("abort_mem_valid", 64'(mem_read_valid), 64'd1);
    checkOutput("abort_mem_addr", 64'(mem_read_address), 64'h10);
    client_read_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_data[i] = 16'h0000;
    checkOutput("abort_mem_valid_clr", 64'(mem_read_valid), 64'd0);
    checkOutput("abort_mem_addr_clr", 64'(mem_read_address), 64'd0);
    checkOutput("abort_data_clr", client_read_data, 64'd0);
    checkOutput("abort_busy_clr", 64'(busy), 64'd0);
    checkOutput("abort_grant_clr", 64'(grant_id), 64'd0);
    step();
    reset          = 1'b0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    step();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    checkOutput("late_ready", 64'(client_read_ready), 64'd0);
    checkOutput("late_data", client_read_data, 64'd0);
    checkOutput("late_busy", 64'(busy), 64'd0);
    step();
    checkOutput("late_ready2", 64'(client_read_ready), 64'd0);
    checkOutput("late_busy2", 64'(busy), 64'd0);

    $display("[TB] pointer restarts at 0 after reset");
    applyStimulus(4'b0110, 32'h0066_6100);
    serve(1, 8'h61, 16'hE001, 1, 4'b0000, 4'b0010);
    serve(2, 8'h66, 16'hE002, 2, 4'b0000, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_mem_arbiter.md
PROGRAM_MEM_ARBITER -- requirements
Module: program_mem_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 4, SHALL set the number of instruction-cache miss ports served (2..8).
REQ-002 Parameter ADDR_BITS, default 8, SHALL set the program memory address width.
REQ-003 Parameter DATA_BITS, default 16, SHALL set the instruction width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous and active-high.
REQ-006 client_read_valid  input  NUM_CLIENTS  SHALL be the per-client level miss request.
REQ-007 client_read_address  input  NUM_CLIENTS*ADDR_BITS  SHALL carry the per-client request addresses; client i uses slice [i*ADDR_BITS +: ADDR_BITS].
REQ-008 client_read_ready  output  NUM_CLIENTS  SHALL be the per-client one-cycle completion pulse.
REQ-009 client_read_data  output  NUM_CLIENTS*DATA_BITS  SHALL carry the per-client returned instructions, sliced like the addresses.
REQ-010 mem_read_valid  output  1  SHALL be the request to program memory.
REQ-011 mem_read_address  output  ADDR_BITS  SHALL be the program memory address.
REQ-012 mem_read_ready  input  1  SHALL be the memory completion pulse; data is valid in the same cycle.
REQ-013 mem_read_data  input  DATA_BITS  SHALL be the memory read data.
REQ-014 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-015 grant_id  output  $clog2(NUM_CLIENTS)  SHALL identify the client currently or most recently granted.

Function
REQ-016 FSM states SHALL be IDLE, REQUEST and RESPOND; the default/illegal encoding SHALL return to IDLE.
REQ-017 IDLE: if any client_read_valid bit is high, the block SHALL grant one client, latch its address, set mem_read_valid=1 and mem_read_address=latched address at that edge, and enter REQUEST.
REQ-018 Arbitration SHALL be round-robin: search starts at priority pointer p and wraps modulo NUM_CLIENTS; after granting client i, p <= (i+1) mod NUM_CLIENTS.
REQ-019 REQUEST: mem_read_valid and mem_read_address SHALL hold stable until mem_read_ready=1.
REQ-020 On the edge where mem_read_ready=1, the block SHALL drop mem_read_valid, write mem_read_data into the granted client's data slice, and enter RESPOND.
REQ-021 RESPOND: client_read_ready[grant_id] SHALL be 1 for exactly this one cycle, all other ready bits 0; the next state SHALL be IDLE.
REQ-022 Each client_read_data slice SHALL stay unchanged until that client's next completion, so a client can sample it in the cycle after its ready pulse.
REQ-023 Latency, with a valid request in IDLE cycle 0 and memory ready in cycle k>=1: mem_read_valid is high in cycles 1..k, client ready is high in cycle k+1, and the next grant is possible in cycle k+2.
REQ-024 Arbitration SHALL be evaluated only in IDLE; requests arriving in REQUEST or RESPOND SHALL wait and SHALL not be lost while their valid stays high.
REQ-025 A client that holds valid high after its ready pulse SHALL be treated as a new request, subject to round-robin order.
REQ-026 mem_read_ready in IDLE or RESPOND SHALL be ignored, with no state or data change.
REQ-027 A client deasserting valid while in REQUEST SHALL NOT abort the transaction; it still receives its ready pulse.
REQ-028 At most one memory request SHALL be outstanding at any time.

Reset
REQ-029 Asserting reset at any time, including mid-REQUEST, SHALL immediately force state=IDLE, p=0, mem_read_valid=0, mem_read_address=0, client_read_ready=0, all client_read_data=0, busy=0 and grant_id=0.
REQ-030 A mem_read_ready arriving after reset releases, belonging to an aborted request, SHALL be ignored per REQ-026.

Verification
REQ-031 Single request, client 2 requests address 0x3C, memory returns 0xBEEF 3 cycles after valid -> mem_read_address=0x3C, client_read_ready=4'b0100 for exactly one cycle, client 2 data slice=0xBEEF and held afterwards.
REQ-032 All four clients request simultaneously from reset, each holding valid until served -> grant order 0,1,2,3, each with one ready pulse, busy high throughout and low for one cycle between transactions.
REQ-033 Fairness: client 0 re-requests immediately after each service while client 3 waits -> client 3 is granted no later than the second grant after its request.
REQ-034 Reset asserted while in REQUEST (client 1, address 0x10), then a late mem_read_ready -> all outputs cleared asynchronously, no client ready pulse, and the state stays IDLE.
REQ-035 Spurious mem_read_ready while IDLE with mem_read_data=0x1234 -> no ready pulse and no client data change.
REQ-036 Client 1 drops valid during REQUEST -> client 1 still receives its ready pulse and data, and no extra grant is issued for it.
